// File: rtl/instr_mem_pkg.sv
// -----------------------------------------------------------------------------
// instr_mem_pkg
// Shared definitions for the instruction fetch memory:
//   - default widths for the PC, instruction and memory size
//   - fault encodings carried on rsp_fault
//   - the all-zero NOP instruction returned alongside a fault
//   - response-register state encoding
//   - fault classification helper (misaligned beats out of range)
// -----------------------------------------------------------------------------
package instr_mem_pkg;

  localparam int DEF_ADDR_WIDTH  = 64;
  localparam int DEF_INSTR_WIDTH = 32;
  localparam int DEF_DEPTH_BYTES = 256;

  localparam logic [1:0] FAULT_OK       = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;

  localparam logic [DEF_INSTR_WIDTH-1:0] NOP_INSTR = '0;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

  // Misalignment is reported even when the address is also out of range.
  function automatic logic [1:0] classify_fault(input logic misaligned,
                                                input logic out_of_range);
    logic [1:0] fault;
    fault = FAULT_OK;
    if (misaligned) begin
      fault = FAULT_MISALIGN;
    end else if (out_of_range) begin
      fault = FAULT_RANGE;
    end
    return fault;
  endfunction

endpackage

// File: rtl/byte_ram.sv
// -----------------------------------------------------------------------------
// byte_ram
// DEPTH_BYTES x 8 storage with one synchronous byte write port and
// INSTR_BYTES combinational read taps at consecutive addresses, so a whole
// instruction is visible in the same cycle its address is presented.
// Contents are never reset.
//
// Ports:
//   clk      in   clock, rising edge
//   i_we     in   write enable for one byte
//   i_waddr  in   byte write address
//   i_wdata  in   byte to write
//   i_raddr  in   address of the lowest byte of the read window
//   o_rdata  out  INSTR_BYTES bytes, byte at i_raddr in [7:0]
// -----------------------------------------------------------------------------
module byte_ram #(
  parameter int DEPTH_BYTES = 256,
  parameter int INSTR_BYTES = 4,
  parameter int AW          = $clog2(DEPTH_BYTES)
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [AW-1:0]            i_waddr,
  input  logic [7:0]               i_wdata,
  input  logic [AW-1:0]            i_raddr,
  output logic [INSTR_BYTES*8-1:0] o_rdata
);

  logic [7:0] r_mem [DEPTH_BYTES];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Tap addresses wrap modulo the memory size; a wrapped window only occurs
  // for out-of-range fetches, whose data the caller discards.
  genvar gi;
  generate
    for (gi = 0; gi < INSTR_BYTES; gi++) begin : g_tap
      assign o_rdata[gi*8 +: 8] = r_mem[i_raddr + AW'(gi)];
    end
  endgenerate

endmodule

// File: rtl/instr_fetch_mem.sv
// -----------------------------------------------------------------------------
// instr_fetch_mem
// Byte-addressed, little-endian instruction memory with a valid/ready fetch
// port, a one-entry registered response stage and a byte-wide load port.
// Misaligned and out-of-range fetches return a zero instruction plus a fault
// code instead of memory data.
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   req_valid/ready  fetch handshake; ready drops during loads or when the
//                    response register is full and not being drained
//   req_pc           byte address of the instruction to fetch
//   rsp_valid/ready  response handshake
//   rsp_instr        fetched instruction (zero on fault)
//   rsp_pc           PC of the response
//   rsp_fault        00 ok, 01 misaligned, 10 out of range
//   load_en/addr/data  single-byte program write
//   load_err         sticky: a load hit an out-of-range address
// -----------------------------------------------------------------------------
module instr_fetch_mem
  import instr_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int DEPTH_BYTES = DEF_DEPTH_BYTES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_WIDTH-1:0]  req_pc,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [INSTR_WIDTH-1:0] rsp_instr,
  output logic [ADDR_WIDTH-1:0]  rsp_pc,
  output logic [1:0]             rsp_fault,
  input  logic                   load_en,
  input  logic [ADDR_WIDTH-1:0]  load_addr,
  input  logic [7:0]             load_data,
  output logic                   load_err
);

  localparam int INSTR_BYTES = INSTR_WIDTH / 8;
  localparam int OFF_W       = $clog2(INSTR_BYTES);
  localparam int MEM_AW      = $clog2(DEPTH_BYTES);

  // Highest PC whose whole instruction still fits, and the first byte
  // address past the end; both compared at full ADDR_WIDTH.
  localparam logic [ADDR_WIDTH-1:0] LAST_PC    = ADDR_WIDTH'(DEPTH_BYTES - INSTR_BYTES);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_ADDR = ADDR_WIDTH'(DEPTH_BYTES);

  rsp_state_e             r_state;
  rsp_state_e             w_state_next;
  logic [INSTR_WIDTH-1:0] r_rsp_instr;
  logic [ADDR_WIDTH-1:0]  r_rsp_pc;
  logic [1:0]             r_rsp_fault;
  logic                   r_load_err;

  logic                   w_req_ready;
  logic                   w_accept;
  logic                   w_misaligned;
  logic                   w_out_of_range;
  logic [1:0]             w_fault;
  logic                   w_load_in_range;
  logic                   w_ram_we;
  logic [INSTR_WIDTH-1:0] w_ram_rdata;
  logic [INSTR_WIDTH-1:0] w_fetch_instr;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  // A load owns the cycle, so fetches never observe a half-written edge.
  assign w_req_ready = !load_en && ((r_state == RSP_EMPTY) || rsp_ready);
  assign w_accept    = req_valid && w_req_ready;

  // ---------------------------------------------------------------------------
  // Fault classification
  // ---------------------------------------------------------------------------
  generate
    if (OFF_W > 0) begin : g_align_check
      assign w_misaligned = |req_pc[OFF_W-1:0];
    end else begin : g_no_align_check
      assign w_misaligned = 1'b0;
    end
  endgenerate

  assign w_out_of_range = (req_pc > LAST_PC);
  assign w_fault        = classify_fault(w_misaligned, w_out_of_range);

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  assign w_load_in_range = (load_addr < DEPTH_ADDR);
  assign w_ram_we        = load_en && w_load_in_range;

  byte_ram #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .INSTR_BYTES (INSTR_BYTES),
    .AW          (MEM_AW)
  ) u_byte_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (load_addr[MEM_AW-1:0]),
    .i_wdata (load_data),
    .i_raddr (req_pc[MEM_AW-1:0]),
    .o_rdata (w_ram_rdata)
  );

  // The read taps are combinational; a faulting fetch simply never lets the
  // tap data reach the response register.
  assign w_fetch_instr = (w_fault == FAULT_OK) ? w_ram_rdata
                                               : INSTR_WIDTH'(NOP_INSTR);

  // ---------------------------------------------------------------------------
  // Response register state machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RSP_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RSP_EMPTY: begin
        if (w_accept) begin
          w_state_next = RSP_FULL;
        end
      end
      RSP_FULL: begin
        // An accept in the same cycle as a drain refills the register.
        if (rsp_ready && !w_accept) begin
          w_state_next = RSP_EMPTY;
        end
      end
      default: begin
        w_state_next = RSP_EMPTY;
      end
    endcase
  end

  // Payload only moves on accept, which keeps it stable while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_instr <= '0;
      r_rsp_pc    <= '0;
      r_rsp_fault <= FAULT_OK;
    end else if (w_accept) begin
      r_rsp_instr <= w_fetch_instr;
      r_rsp_pc    <= req_pc;
      r_rsp_fault <= w_fault;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky load error
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_load_err <= 1'b0;
    end else if (load_en && !w_load_in_range) begin
      r_load_err <= 1'b1;
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = (r_state == RSP_FULL);
  assign rsp_instr = r_rsp_instr;
  assign rsp_pc    = r_rsp_pc;
  assign rsp_fault = r_rsp_fault;
  assign load_err  = r_load_err;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_mem
// Directed bench for instr_fetch_mem. Inputs change 1 time unit after the
// rising edge; outputs are sampled at that same point or after a further
// 1 unit of combinational settling.
// -----------------------------------------------------------------------------
module tb_instr_fetch_mem;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_pc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [63:0] rsp_pc;
  logic [1:0]  rsp_fault;
  logic        load_en;
  logic [63:0] load_addr;
  logic [7:0]  load_data;
  logic        load_err;

  int vectors;
  int miscompares;

  instr_fetch_mem dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_pc    (req_pc),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_pc    (rsp_pc),
    .rsp_fault (rsp_fault),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .load_err  (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [63:0] addr, input logic [7:0] data);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    tick();
    load_en   = 1'b0;
    $display("load  addr=%0d data=0x%02h", addr, data);
  endtask

  task automatic load_word(input logic [63:0] addr, input logic [31:0] word);
    for (int b = 0; b < 4; b++) begin
      load_byte(addr + 64'(b), word[b*8 +: 8]);
    end
  endtask

  // One accepted fetch with the consumer ready; the response is visible
  // when this returns.
  task automatic fetch(input logic [63:0] pc);
    req_valid = 1'b1;
    req_pc    = pc;
    tick();
    req_valid = 1'b0;
    $display("fetch pc=%0d -> valid=%0b instr=0x%08h pc=%0d fault=%02b",
             pc, rsp_valid, rsp_instr, rsp_pc, rsp_fault);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_pc = '0; rsp_ready = 1'b1;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_instr !== 32'h0 || rsp_pc !== 64'h0 ||
        rsp_fault !== 2'b00 || load_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: valid=%0b instr=%h pc=%0d fault=%b err=%0b, required all zero",
               rsp_valid, rsp_instr, rsp_pc, rsp_fault, load_err);
    end
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_req_ready: got %0b, required 1", req_ready);
    end
    $display("reset done");
  endtask

  task automatic test_basic_fetch();
    load_word(64'd0, 32'h0000_0033);
    req_valid = 1'b1; req_pc = 64'd0; rsp_ready = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_req_ready: got %0b, required 1", req_ready);
    end
    tick();
    req_valid = 1'b0;
    $display("fetch pc=0 -> instr=0x%08h fault=%02b", rsp_instr, rsp_fault);
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_instr !== 32'h0000_0033 || rsp_pc !== 64'd0 ||
        rsp_fault !== 2'b00) begin
      miscompares++;
      $display("FAIL basic_fetch: valid=%0b instr=%h pc=%0d fault=%b, required 1/00000033/0/00",
               rsp_valid, rsp_instr, rsp_pc, rsp_fault);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] pcs   [2];
    logic [31:0] words [2];
    pcs[0] = 64'd4; words[0] = 32'h0000_0003;
    pcs[1] = 64'd8; words[1] = 32'h0000_0023;
    load_word(pcs[0], words[0]);
    load_word(pcs[1], words[1]);
    rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid = 1'b1; req_pc = pcs[i];
      #1;
      vectors++;
      if (req_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_req_ready[%0d]: got %0b, required 1", i, req_ready);
      end
      tick();
      $display("b2b   pc=%0d -> instr=0x%08h rsp_pc=%0d", pcs[i], rsp_instr, rsp_pc);
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_instr !== words[i] || rsp_pc !== pcs[i]) begin
        miscompares++;
        $display("FAIL b2b_rsp[%0d]: valid=%0b instr=%h pc=%0d, required 1/%h/%0d",
                 i, rsp_valid, rsp_instr, rsp_pc, words[i], pcs[i]);
      end
    end
    req_valid = 1'b0;
    tick();
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_drain: rsp_valid=%0b, required 0", rsp_valid);
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b1;
    fetch(64'd0);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_pc = 64'd4;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if (req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_req_ready[%0d]: got %0b, required 0", c, req_ready);
      end
      tick();
      $display("stall cycle %0d -> instr=0x%08h pc=%0d", c, rsp_instr, rsp_pc);
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_instr !== 32'h0000_0033 || rsp_pc !== 64'd0) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: valid=%0b instr=%h pc=%0d, required 1/00000033/0",
                 c, rsp_valid, rsp_instr, rsp_pc);
      end
    end
    rsp_ready = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL release_req_ready: got %0b, required 1", req_ready);
    end
    tick();
    req_valid = 1'b0;
    $display("release -> instr=0x%08h pc=%0d", rsp_instr, rsp_pc);
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_instr !== 32'h0000_0003 || rsp_pc !== 64'd4) begin
      miscompares++;
      $display("FAIL release_rsp: valid=%0b instr=%h pc=%0d, required 1/00000003/4",
               rsp_valid, rsp_instr, rsp_pc);
    end
    tick();
  endtask

  task automatic test_faults();
    logic [63:0] pcs    [5];
    logic [1:0]  faults [5];
    logic [31:0] words  [5];
    // Top aligned slot also checks little-endian byte placement.
    load_byte(64'd252, 8'h11);
    load_byte(64'd253, 8'h22);
    load_byte(64'd254, 8'h33);
    load_byte(64'd255, 8'h44);
    pcs[0] = 64'd2;              faults[0] = 2'b01; words[0] = 32'h0;
    pcs[1] = 64'd256;            faults[1] = 2'b10; words[1] = 32'h0;
    pcs[2] = 64'd254;            faults[2] = 2'b01; words[2] = 32'h0;
    pcs[3] = 64'd252;            faults[3] = 2'b00; words[3] = 32'h4433_2211;
    pcs[4] = 64'h1_0000_0000;    faults[4] = 2'b10; words[4] = 32'h0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      fetch(pcs[i]);
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_fault !== faults[i] || rsp_instr !== words[i] ||
          rsp_pc !== pcs[i]) begin
        miscompares++;
        $display("FAIL fault_case[%0d]: valid=%0b fault=%b instr=%h pc=%h, required 1/%b/%h/%h",
                 i, rsp_valid, rsp_fault, rsp_instr, rsp_pc, faults[i], words[i], pcs[i]);
      end
    end
    tick();
  endtask

  task automatic test_load_port();
    load_word(64'd44, 32'h0);
    load_word(64'd48, 32'h0);
    vectors++;
    if (load_err !== 1'b0) begin
      miscompares++;
      $display("FAIL load_err_clear: got %0b, required 0", load_err);
    end
    // 300 aliases to 44 if the range check were skipped.
    load_byte(64'd300, 8'hAA);
    vectors++;
    if (load_err !== 1'b1) begin
      miscompares++;
      $display("FAIL load_err_set: got %0b, required 1", load_err);
    end
    rsp_ready = 1'b1;
    fetch(64'd44);
    vectors++;
    if (rsp_instr !== 32'h0 || rsp_fault !== 2'b00) begin
      miscompares++;
      $display("FAIL load_dropped: instr=%h fault=%b, required 00000000/00", rsp_instr, rsp_fault);
    end
    repeat (2) tick();
    vectors++;
    if (load_err !== 1'b1) begin
      miscompares++;
      $display("FAIL load_err_sticky: got %0b, required 1", load_err);
    end
    // Load and fetch presented together: the load wins the cycle.
    load_en = 1'b1; load_addr = 64'd48; load_data = 8'h5A;
    req_valid = 1'b1; req_pc = 64'd48;
    #1;
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL load_blocks_fetch: req_ready=%0b, required 0", req_ready);
    end
    tick();
    load_en = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL load_no_accept: rsp_valid=%0b, required 0", rsp_valid);
    end
    tick();
    req_valid = 1'b0;
    $display("fetch after load pc=48 -> instr=0x%08h", rsp_instr);
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_instr !== 32'h0000_005A) begin
      miscompares++;
      $display("FAIL fetch_after_load: valid=%0b instr=%h, required 1/0000005a", rsp_valid, rsp_instr);
    end
    tick();
  endtask

  task automatic test_reset_midstream();
    rsp_ready = 1'b0;
    fetch(64'd8);
    vectors++;
    if (rsp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_valid: got %0b, required 1", rsp_valid);
    end
    rst = 1'b1;
    #1;
    $display("async reset -> valid=%0b instr=0x%08h err=%0b", rsp_valid, rsp_instr, load_err);
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_instr !== 32'h0 || rsp_pc !== 64'h0 ||
        rsp_fault !== 2'b00 || load_err !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: valid=%0b instr=%h pc=%0d fault=%b err=%0b, required all zero",
               rsp_valid, rsp_instr, rsp_pc, rsp_fault, load_err);
    end
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    tick();
    fetch(64'd0);
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_instr !== 32'h0000_0033 || rsp_fault !== 2'b00) begin
      miscompares++;
      $display("FAIL mem_retained: valid=%0b instr=%h fault=%b, required 1/00000033/00",
               rsp_valid, rsp_instr, rsp_fault);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic_fetch();
    test_back_to_back();
    test_backpressure();
    test_faults();
    test_load_port();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
